pea_cfg_loader: RTL and testbench

PEA_CFG_LOADER -- requirements
Module: pea_cfg_loader

---
 rtl/pea_pkg.sv | 18 +
 rtl/pea_cfg_loader.sv | 109 ++++++++++
 tb/tb_pea_cfg_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the PEA configuration path: array geometry,
// total configuration word count and the loader state type.
package pea_pkg;

  localparam int N             = 4;
  localparam int M             = 4;
  localparam int N_CFG_REGS_PE = 2;

  // Number of 32-bit words needed to fill the whole PEA register image.
  localparam int N_CFG_WORDS_PEA = N * M * N_CFG_REGS_PE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } pea_cfg_ld_state_t;

endpackage

// File: rtl/pea_cfg_loader.sv
// Streams 32-bit configuration words into the PEA register image.
// Order is reg-major inside a PE, then column, then row. The image is only
// flagged valid after a complete, uninterrupted load.
module pea_cfg_loader #(
  parameter int N             = pea_pkg::N,
  parameter int M             = pea_pkg::M,
  parameter int N_CFG_REGS_PE = pea_pkg::N_CFG_REGS_PE
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            start_i,
  input  logic                                            abort_i,
  input  logic                                            data_valid_i,
  input  logic [31:0]                                     data_i,
  output logic                                            data_ready_o,
  output logic [N-1:0][M-1:0][N_CFG_REGS_PE-1:0][31:0]    reg_cfg_pea_o,
  output logic                                            cfg_valid_o,
  output logic                                            done_o,
  output logic [$clog2(N*M*N_CFG_REGS_PE+1)-1:0]          word_cnt_o
);

  localparam int N_WORDS = N * M * N_CFG_REGS_PE;
  localparam int ROW_W   = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W   = (M > 1) ? $clog2(M) : 1;
  localparam int REG_W   = (N_CFG_REGS_PE > 1) ? $clog2(N_CFG_REGS_PE) : 1;
  localparam int CNT_W   = $clog2(N_WORDS + 1);

  pea_pkg::pea_cfg_ld_state_t state;

  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;
  logic [REG_W-1:0] reg_idx;

  logic last_reg;
  logic last_col;
  logic last_row;

  // Handshake is purely a function of the state and the cancel request, so a
  // word arriving together with abort_i is never taken.
  assign data_ready_o = (state == pea_pkg::LOAD) && !abort_i;

  assign last_reg = (reg_idx == REG_W'(N_CFG_REGS_PE - 1));
  assign last_col = (col_idx == COL_W'(M - 1));
  assign last_row = (row_idx == ROW_W'(N - 1));

  // Load sequencer: walks the image indices, writes accepted words and
  // produces the completion pulse and the image-valid flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= pea_pkg::IDLE;
      row_idx       <= '0;
      col_idx       <= '0;
      reg_idx       <= '0;
      word_cnt_o    <= '0;
      cfg_valid_o   <= 1'b0;
      done_o        <= 1'b0;
      reg_cfg_pea_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        pea_pkg::IDLE: begin
          if (start_i) begin
            row_idx     <= '0;
            col_idx     <= '0;
            reg_idx     <= '0;
            word_cnt_o  <= '0;
            cfg_valid_o <= 1'b0;
            state       <= pea_pkg::LOAD;
          end
        end
        pea_pkg::LOAD: begin
          if (abort_i) begin
            state <= pea_pkg::IDLE;
          end else if (data_valid_i) begin
            reg_cfg_pea_o[row_idx][col_idx][reg_idx] <= data_i;
            if (word_cnt_o != CNT_W'(N_WORDS)) begin
              word_cnt_o <= word_cnt_o + CNT_W'(1);
            end
            if (last_reg) begin
              reg_idx <= '0;
              if (last_col) begin
                col_idx <= '0;
                if (!last_row) begin
                  row_idx <= row_idx + ROW_W'(1);
                end
              end else begin
                col_idx <= col_idx + COL_W'(1);
              end
            end else begin
              reg_idx <= reg_idx + REG_W'(1);
            end
            if (last_reg && last_col && last_row) begin
              done_o <= 1'b1;
              state  <= pea_pkg::DONE;
            end
          end
        end
        pea_pkg::DONE: begin
          cfg_valid_o <= 1'b1;
          state       <= pea_pkg::IDLE;
        end
        default: begin
          state <= pea_pkg::IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pea_cfg_loader.sv
// Self-checking bench for pea_cfg_loader: directed scenarios plus a random
// phase, all compared against a flat-array behavioural model.
module tb_pea_cfg_loader;
  import pea_pkg::*;

  localparam int NR = N;
  localparam int NC = M;
  localparam int NG = N_CFG_REGS_PE;
  localparam int NW = N_CFG_WORDS_PEA;
  localparam int CW = $clog2(NW + 1);

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_DONE = 2;

  logic                                clk_i = 1'b0;
  logic                                rst_i;
  logic                                start_i;
  logic                                abort_i;
  logic                                data_valid_i;
  logic [31:0]                         data_i;
  logic                                data_ready_o;
  logic [NR-1:0][NC-1:0][NG-1:0][31:0] reg_cfg_pea_o;
  logic                                cfg_valid_o;
  logic                                done_o;
  logic [CW-1:0]                       word_cnt_o;

  int assertCount = 0;
  int failCount   = 0;
  int doneSeen    = 0;

  // Behavioural model: the image is a flat list of words in load order.
  int          mPhase;
  int          mPos;
  int          mCnt;
  bit          mValid;
  bit          mDone;
  int          mDoneCount;
  logic [31:0] mImg [NW];

  pea_cfg_loader #(.N(NR), .M(NC), .N_CFG_REGS_PE(NG)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .reg_cfg_pea_o(reg_cfg_pea_o),
    .cfg_valid_o  (cfg_valid_o),
    .done_o       (done_o),
    .word_cnt_o   (word_cnt_o)
  );

  // Free-running 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = P_IDLE;
    mPos   = 0;
    mCnt   = 0;
    mValid = 1'b0;
    mDone  = 1'b0;
    for (int k = 0; k < NW; k++) mImg[k] = '0;
  endtask

  task automatic modelStep(input bit s, input bit a, input bit v, input logic [31:0] d);
    mDone = 1'b0;
    if (mPhase == P_IDLE) begin
      if (s) begin
        mPos   = 0;
        mCnt   = 0;
        mValid = 1'b0;
        mPhase = P_LOAD;
      end
    end else if (mPhase == P_LOAD) begin
      if (a) begin
        mPhase = P_IDLE;
      end else if (v) begin
        mImg[mPos] = d;
        mPos++;
        mCnt = (mCnt + 1 > NW) ? NW : mCnt + 1;
        if (mPos == NW) begin
          mPhase = P_DONE;
          mDone  = 1'b1;
          mDoneCount++;
        end
      end
    end else begin
      mValid = 1'b1;
      mPhase = P_IDLE;
    end
  endtask

  task automatic checkSignals();
    checkOutput("word_cnt", 32'(word_cnt_o), 32'(mCnt));
    checkOutput("cfg_valid", 32'(cfg_valid_o), 32'(mValid));
    checkOutput("done", 32'(done_o), 32'(mDone));
  endtask

  task automatic checkImage(input string tag);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        for (int g = 0; g < NG; g++)
          checkOutput(tag, reg_cfg_pea_o[r][c][g], mImg[(r * NC + c) * NG + g]);
  endtask

  // One clock cycle: drive at the falling edge, check ready, step the model
  // on the rising edge and check registered outputs at the next falling edge.
  task automatic applyStimulus(input bit s, input bit a, input bit v, input logic [31:0] d);
    start_i      = s;
    abort_i      = a;
    data_valid_i = v;
    data_i       = d;
    #1;
    checkOutput("data_ready", 32'(data_ready_o), 32'((mPhase == P_LOAD) && !a));
    modelStep(s, a, v, d);
    @(posedge clk_i);
    @(negedge clk_i);
    if (done_o) doneSeen++;
    checkSignals();
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps.
  task automatic sendWords(input int first, input int count, input int mode, input bit incData);
    for (int k = first; k < first + count; k++) begin
      if (mode == 1 && k != first) applyStimulus(1'b0, 1'b0, 1'b0, $urandom);
      if (mode == 2) begin
        int gaps = $urandom_range(0, 2);
        for (int j = 0; j < gaps; j++) applyStimulus(1'b0, 1'b0, 1'b0, $urandom);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, incData ? 32'h1000 + 32'(k) : $urandom);
    end
  endtask

  task automatic fullLoad(input int mode, input bit incData);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    sendWords(0, NW, mode, incData);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int doneBase;
    logic [31:0] keep;
    mDoneCount   = 0;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkSignals();
    checkImage("reset_img");

    $display("[TB] full load with incrementing data");
    doneBase = doneSeen;
    fullLoad(0, 1'b1);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        for (int g = 0; g < NG; g++)
          checkOutput("img_fmt", reg_cfg_pea_o[r][c][g], 32'h1000 + 32'(r * NC * NG + c * NG + g));
    checkOutput("done_b2b", 32'(doneSeen - doneBase), 32'd1);

    $display("[TB] full load with valid toggling");
    doneBase = doneSeen;
    fullLoad(1, 1'b1);
    checkImage("img_toggle");
    checkOutput("cnt_toggle", 32'(word_cnt_o), 32'(NW));
    checkOutput("done_toggle", 32'(doneSeen - doneBase), 32'd1);

    $display("[TB] random data load");
    fullLoad(2, 1'b0);
    checkImage("img_rand");

    $display("[TB] abort together with word 10");
    doneBase = doneSeen;
    keep = mImg[10];
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    sendWords(0, 10, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    checkOutput("abort_cnt", 32'(word_cnt_o), 32'd10);
    checkOutput("abort_keep", reg_cfg_pea_o[1][1][0], keep);
    checkOutput("abort_done", 32'(doneSeen - doneBase), 32'd0);
    checkImage("img_abort");

    $display("[TB] start during load at word 5");
    doneBase = doneSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    sendWords(0, 5, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
    sendWords(6, NW - 6, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("restart_done", 32'(doneSeen - doneBase), 32'd1);
    checkImage("img_restart");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    sendWords(0, NW, 0, 1'b0);
    checkImage("img_restart_run");

    $display("[TB] asynchronous reset at word 20");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    fullLoad(0, 1'b0);
    doneBase = doneSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    sendWords(0, 20, 0, 1'b0);
    data_valid_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    modelReset();
    checkSignals();
    checkOutput("rst_ready", 32'(data_ready_o), 32'd0);
    checkImage("img_rst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
    checkOutput("rst_no_done", 32'(doneSeen - doneBase), 32'd0);
    fullLoad(2, 1'b0);
    checkImage("img_after_rst");
    checkOutput("rst_reload_valid", 32'(cfg_valid_o), 32'd1);

    $display("[TB] valid data in IDLE");
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkImage("img_idle");

    $display("[TB] random control traffic");
    doneBase = doneSeen;
    mDoneCount = 0;
    for (int j = 0; j < 600; j++)
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0,
                    1'($urandom_range(0, 1)), $urandom);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkImage("img_random");
    checkOutput("random_dones", 32'(doneSeen - doneBase), 32'(mDoneCount));

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
